rr_hold_arbiter: RTL and testbench
==================================

Name: rr_hold_arbiter

Overview:
- Parametrised N-channel arbiter for the optical switch control path.
- Issues one registered one-hot grant per arbitration.
- Priority source is selectable per arbitration:
  - mode 0: fixed, using an externally supplied start priority.
  - mode 1: round-robin, using an internally rotating pointer.
- The grant is held until the owner releases it, so one channel owns the shared resource (e.g. a switch port) for a multi-cycle transaction.

Parameters:
- P_CHANNEL_NUM, 8, number of requesters (≥2).
- P_IDX_W, $clog2(P_CHANNEL_NUM), width of the binary grant index.
- P_TIMEOUT, 255, maximum hold cycles before a forced release (used only with ARB_TIMEOUT_EN).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-low (0 = reset, sampled on i_clk rising edge).
- i_req  in  P_CHANNEL_NUM  request vector, bit k = channel k.
- i_first_priority  in  P_CHANNEL_NUM  mode-0 start-priority one-hot.
- i_mode  in  1  0 = fixed/external priority, 1 = round-robin.
- i_req_valid  in  1  arbitration strobe.
- i_release  in  1  owner done; single-cycle pulse.
- o_grant  out  P_CHANNEL_NUM  one-hot grant, held.
- o_grant_idx  out  P_IDX_W  binary index of the granted channel.
- o_grant_valid  out  1  high while a grant is held.
- o_busy  out  1  high in GRANT state.
- o_timeout  out  1  one-cycle forced-release pulse.

Behaviour:
- Reset (i_rst=0 at an edge): every output is 0; state = IDLE; RR pointer = 1 (channel 0); hold counter = 0. Reset overrides any grant in progress.
- State IDLE:
  - i_req_valid=1 and i_req≠0: arbitrate on i_req and move to GRANT. Next cycle o_grant / o_grant_idx / o_grant_valid=1 / o_busy=1. Latency is 1 cycle.
  - i_req_valid=1 and i_req=0: stay IDLE, outputs remain 0.
  - i_release in IDLE is ignored.
- Arbitration:
  - Priority vector P is i_first_priority when i_mode=0, otherwise the RR pointer. i_mode is sampled only in the arbitration cycle.
  - P is normalised: P=0 is treated as 1; multiple bits set means the lowest set bit is used.
  - Winner is the first set bit of i_req searching upward from P's position, wrapping from bit N-1 to bit 0. Implemented as a 2N-bit double-request subtract: grant = D & ~(D − P), with the two halves ORed.
- State GRANT:
  - o_grant is held regardless of i_req changes, including the owner dropping its request.
  - i_req_valid is ignored while in GRANT.
  - On i_release=1: next cycle o_grant=0, o_grant_valid=0, o_busy=0, state = IDLE.
  - If the grant was issued in mode 1, the RR pointer becomes the granted one-hot rotated left by 1 (bit N-1 wraps to bit 0). A mode-0 grant leaves the pointer unchanged.
- Back-to-back: at least one cycle with o_grant_valid=0 separates consecutive grants. A release at cycle t gives the earliest new arbitration at t+1 and a new grant visible at t+2.
- o_grant_idx is always the encoding of o_grant, and 0 when there is no grant.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to GRANT and increments every GRANT cycle.
  - When it reaches P_TIMEOUT−1 without i_release, the block force-releases exactly as for i_release. o_timeout=1 in the same cycle the grant deasserts. The RR pointer advances as for a normal release.
  - If i_release coincides with the terminal count, it is a normal release and o_timeout stays 0.
- Undefined: no counter; o_timeout is tied 0 and the grant is held indefinitely until i_release.

Test Plan:
- Reset, then mode 1 with i_req=8'b1010_0100 and i_req_valid pulsed → next cycle o_grant=0000_0100, idx=2, valid=1. Release → pointer=0000_1000; re-arbitrate with the same req → grant 0010_0000, idx=5.
- Wrap-around: mode 1, pointer at 1000_0000 (after a ch6 grant), i_req=0000_0011 → grant 0000_0001, idx=0. After release, pointer=0000_0010.
- Mode 0: i_first_priority=0001_0000, i_req=0000_1001 → grant 0000_0001 (wrap). i_first_priority=0 → treated as bit0 → grant 0000_0001. RR pointer unchanged across both.
- Hold behaviour:
  - With ch3 granted, drop i_req to 0 and pulse i_req_valid with i_req=0xFF → grant stays 0000_1000 until release.
  - Release → one idle cycle with valid=0, then the new grant.
- Reset mid-operation: assert i_rst=0 during GRANT → next edge all outputs 0 and pointer=0000_0001. i_req_valid=1 with i_req=0 → no grant.
- ARB_TIMEOUT_EN, P_TIMEOUT=4: grant ch1 with no release → after the 4th GRANT cycle o_grant=0 and o_timeout pulses for 1 cycle. Repeat with release on the terminal cycle → o_timeout stays 0.

Source files
------------

// File: rtl/rr_hold_arbiter_if.sv
// Handshake bundle between a requester block and rr_hold_arbiter.
// master: the requesting side (drives requests, strobe and release).
// slave : the arbiter side (drives the held grant and status).
interface rr_hold_arbiter_if #(
    parameter int P_CHANNEL_NUM = 8,
    parameter int P_IDX_W       = $clog2(P_CHANNEL_NUM)
);
    logic [P_CHANNEL_NUM-1:0] i_req;
    logic [P_CHANNEL_NUM-1:0] i_first_priority;
    logic                     i_mode;
    logic                     i_req_valid;
    logic                     i_release;
    logic [P_CHANNEL_NUM-1:0] o_grant;
    logic [P_IDX_W-1:0]       o_grant_idx;
    logic                     o_grant_valid;
    logic                     o_busy;
    logic                     o_timeout;

    modport master (
        output i_req, i_first_priority, i_mode, i_req_valid, i_release,
        input  o_grant, o_grant_idx, o_grant_valid, o_busy, o_timeout
    );

    modport slave (
        input  i_req, i_first_priority, i_mode, i_req_valid, i_release,
        output o_grant, o_grant_idx, o_grant_valid, o_busy, o_timeout
    );
endinterface

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: N-channel arbiter issuing a registered one-hot grant that
// is held until the owner releases it. Priority per arbitration is either an
// external start priority (mode 0) or an internal round-robin pointer (mode 1).
// Optional feature macro: ARB_TIMEOUT_EN -- forced release after P_TIMEOUT
// grant cycles, flagged by a one-cycle o_timeout pulse.
module rr_hold_arbiter #(
    parameter int P_CHANNEL_NUM = 8,
    parameter int P_IDX_W       = $clog2(P_CHANNEL_NUM),
    parameter int P_TIMEOUT     = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    rr_hold_arbiter_if.slave  arb
);
    localparam int N  = P_CHANNEL_NUM;
    localparam int W2 = 2 * P_CHANNEL_NUM;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]         state;
    logic [N-1:0]       rr_ptr;
    logic [N-1:0]       grant_q;
    logic [P_IDX_W-1:0] idx_q;
    logic               valid_q;
    logic               busy_q;
    logic               timeout_q;
    logic               rr_owner;

    logic [N-1:0]       prio_sel;
    logic [N-1:0]       prio_norm;
    logic [W2-1:0]      dbl_req;
    logic [W2-1:0]      dbl_diff;
    logic [W2-1:0]      dbl_win;
    logic [N-1:0]       win;
    logic [P_IDX_W-1:0] win_idx;
    logic               forced_release;
    logic               release_now;

    // Winner search: first request at or above the priority bit, wrapping.
    // Doubling the request vector turns the wrap into a single subtraction.
    always_comb begin
        prio_sel  = arb.i_mode ? rr_ptr : arb.i_first_priority;
        prio_norm = prio_sel & (~prio_sel + N'(1));
        if (prio_norm == '0) begin
            prio_norm = N'(1);
        end
        dbl_req  = {arb.i_req, arb.i_req};
        dbl_diff = dbl_req - {{N{1'b0}}, prio_norm};
        dbl_win  = dbl_req & ~dbl_diff;
        win      = dbl_win[N-1:0] | dbl_win[W2-1:N];
        win_idx  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (win[k]) begin
                win_idx = win_idx | P_IDX_W'(k);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(P_TIMEOUT + 1);
    localparam logic [CW-1:0] TERM = CW'(P_TIMEOUT - 1);

    logic [CW-1:0] hold_cnt;

    // Hold counter: zero while idle (so it is clear on entry), counts grant cycles.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            hold_cnt <= '0;
        end else if (state == ST_IDLE || release_now) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + CW'(1);
        end
    end

    // An owner release on the terminal cycle wins, so no timeout is flagged then.
    assign forced_release = (state == ST_GRANT) && (hold_cnt == TERM) && !arb.i_release;
`else
    assign forced_release = 1'b0;
`endif

    assign release_now = arb.i_release | forced_release;

    // Grant FSM: arbitrate from IDLE, hold the grant until a (forced) release.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= N'(1);
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            rr_owner  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb.i_req_valid && (arb.i_req != '0)) begin
                        state    <= ST_GRANT;
                        grant_q  <= win;
                        idx_q    <= win_idx;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        rr_owner <= arb.i_mode;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        state     <= ST_IDLE;
                        grant_q   <= '0;
                        idx_q     <= '0;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        timeout_q <= forced_release;
                        if (rr_owner) begin
                            rr_ptr <= {grant_q[N-2:0], grant_q[N-1]};
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign arb.o_grant       = grant_q;
    assign arb.o_grant_idx   = idx_q;
    assign arb.o_grant_valid = valid_q;
    assign arb.o_busy        = busy_q;
    assign arb.o_timeout     = timeout_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Scoreboard bench for rr_hold_arbiter: the stimulus process computes each
// expected grant from a channel-index reference model and queues it; a
// negedge monitor pops and compares whenever a new grant appears and checks
// the hold/idle output relationships every cycle.
module tb_rr_hold_arbiter;
    localparam int N  = 8;
    localparam int IW = 3;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    typedef struct packed {
        logic [N-1:0]  g;
        logic [IW-1:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rr_hold_arbiter_if #(.P_CHANNEL_NUM(N), .P_IDX_W(IW)) bus ();

    rr_hold_arbiter #(.P_CHANNEL_NUM(N), .P_IDX_W(IW), .P_TIMEOUT(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .arb   (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t cur;
    logic prev_valid = 1'b0;

    // Reference model state: round-robin start channel and current owner.
    int   rr_pos    = 0;
    logic granted   = 1'b0;
    logic held_mode = 1'b0;
    int   held_win  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int lowest_bit(input logic [N-1:0] p);
        for (int k = 0; k < N; k++) begin
            if (p[k]) return k;
        end
        return 0;
    endfunction

    function automatic int search(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "_grant"}, bus.o_grant, 0);
        check({name, "_idx"}, bus.o_grant_idx, 0);
        check({name, "_valid"}, bus.o_grant_valid, 0);
        check({name, "_busy"}, bus.o_busy, 0);
        check({name, "_timeout"}, bus.o_timeout, 0);
    endtask

    task automatic arbitrate(input logic [N-1:0] req, input logic [N-1:0] fp,
                             input logic mode, output int win);
        int   start;
        exp_t e;
        @(posedge clk); #1;
        bus.i_req            = req;
        bus.i_first_priority = fp;
        bus.i_mode           = mode;
        bus.i_req_valid      = 1'b1;
        start = mode ? rr_pos : lowest_bit(fp);
        win   = search(req, start);
        if (win >= 0) begin
            e.g   = N'(1) << win;
            e.idx = IW'(win);
            exp_q.push_back(e);
            granted   = 1'b1;
            held_mode = mode;
            held_win  = win;
        end
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
    endtask

    function automatic void model_release();
        if (granted && held_mode) rr_pos = (held_win + 1) % N;
        granted = 1'b0;
    endfunction

    task automatic release_grant();
        @(posedge clk); #1;
        bus.i_release = 1'b1;
        @(posedge clk); #1;
        bus.i_release = 1'b0;
        check("valid_after_release", bus.o_grant_valid, 0);
        model_release();
    endtask

    // Monitor: pop an expectation on each new grant, verify hold and idle state.
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.o_grant_valid && !prev_valid) begin
                check("grant_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("new_grant", bus.o_grant, cur.g);
                    check("new_idx", bus.o_grant_idx, cur.idx);
                end
            end
            if (bus.o_grant_valid) begin
                check("held_grant", bus.o_grant, cur.g);
                check("held_idx", bus.o_grant_idx, cur.idx);
                check("busy_high", bus.o_busy, 1);
            end else begin
                check("idle_grant", bus.o_grant, 0);
                check("idle_idx", bus.o_grant_idx, 0);
                check("idle_busy", bus.o_busy, 0);
            end
`ifdef ARB_TIMEOUT_EN
            if (bus.o_timeout) check("timeout_without_grant", bus.o_grant_valid, 0);
`else
            check("timeout_tied_low", bus.o_timeout, 0);
`endif
            prev_valid = bus.o_grant_valid;
        end
    end

    initial begin
        int w;
        logic [N-1:0] r;
        logic [N-1:0] fp;
        bus.i_req            = '0;
        bus.i_first_priority = '0;
        bus.i_mode           = 1'b0;
        bus.i_req_valid      = 1'b0;
        bus.i_release        = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        // Round-robin: ch2, pointer to 3, then ch5
        arbitrate(8'b1010_0100, '0, 1'b1, w);
        release_grant();
        arbitrate(8'b1010_0100, '0, 1'b1, w);
        release_grant();

        // Wrap-around: ch6 grant puts pointer at bit7, then ch0, then ch1
        arbitrate(8'b0100_0000, '0, 1'b1, w);
        release_grant();
        arbitrate(8'b0000_0011, '0, 1'b1, w);
        release_grant();
        arbitrate(8'b0000_0011, '0, 1'b1, w);
        release_grant();

        // Fixed priority: wrap, zero priority, multi-bit priority
        arbitrate(8'b0000_1001, 8'b0001_0000, 1'b0, w);
        release_grant();
        arbitrate(8'b0000_1001, 8'b0000_0000, 1'b0, w);
        release_grant();
        arbitrate(8'b0011_0000, 8'b0010_1000, 1'b0, w);
        release_grant();
        // Pointer untouched by mode 0 grants (still at bit2)
        arbitrate(8'hFF, '0, 1'b1, w);
        release_grant();

        // Hold: requests drop and strobes are ignored while granted
        arbitrate(8'b0000_1000, '0, 1'b1, w);
        bus.i_req = '0;
        @(posedge clk); #1;
        bus.i_req       = 8'hFF;
        bus.i_req_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("hold_grant_ch3", bus.o_grant, 8'b0000_1000);
        release_grant();
        // Back-to-back: earliest re-arbitration right after the release
        arbitrate(8'hFF, '0, 1'b1, w);
        check("b2b_valid", bus.o_grant_valid, 1);
        release_grant();

        // Reset during a grant
        arbitrate(8'b0100_0000, '0, 1'b1, w);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("mid_reset");
        rst = 1'b1;
        rr_pos  = 0;
        granted = 1'b0;
        arbitrate('0, '0, 1'b1, w);
        @(posedge clk); #1;
        check("no_grant_on_zero_req", bus.o_grant_valid, 0);
        // Release in idle is ignored
        bus.i_release = 1'b1;
        @(posedge clk); #1;
        bus.i_release = 1'b0;
        check("idle_release_ignored", bus.o_grant_valid, 0);
        arbitrate(8'hFF, '0, 1'b1, w);
        check("after_reset_ptr_ch0", bus.o_grant, 8'b0000_0001);
        release_grant();

`ifdef ARB_TIMEOUT_EN
        begin
            int hi;
            int to;
            hi = 0;
            to = 0;
            arbitrate(8'b0000_0010, '0, 1'b1, w);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.o_grant_valid) hi++;
                if (bus.o_timeout) to++;
                if (!bus.o_grant_valid) break;
            end
            check("timeout_hold_cycles", hi, TO);
            check("timeout_pulse_seen", to, 1);
            @(negedge clk);
            check("timeout_one_cycle", bus.o_timeout, 0);
            model_release();
            // Release coinciding with the terminal count
            arbitrate(8'b0000_0010, 8'b0000_0010, 1'b0, w);
            repeat (2) @(posedge clk);
            release_grant();
            check("terminal_release_no_timeout", bus.o_timeout, 0);
        end
`endif

        // Randomised traffic against the reference model
        for (int t = 0; t < 150; t++) begin
            r  = N'($urandom);
            fp = N'($urandom);
            if ($urandom_range(0, 7) == 0) r = '0;
            if ($urandom_range(0, 3) == 0) fp = '0;
            arbitrate(r, fp, 1'($urandom_range(0, 1)), w);
            if (w >= 0) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    bus.i_req       = N'($urandom);
                    bus.i_req_valid = 1'($urandom_range(0, 1));
                end
                bus.i_req_valid = 1'b0;
                release_grant();
            end else begin
                @(posedge clk); #1;
                bus.i_release = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                bus.i_release = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #2_000_000;
        $display("FAIL time_bound actual=expired required=finished");
        $fatal(1, "time bound expired");
    end
endmodule
